uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Packet-level round-robin arbiter that shares the single byte-wide AXI-stream transmit input of the UART among N_SRC requesters. Each requester owns the channel from its first accepted byte until the byte with tlast is accepted. The block can prefix each packet with a source-ID header byte so the far end can demultiplex. It sits between the command/telemetry sources and the UART `s_axis_*` port, and drives that port from a registered output stage.

## Interface
- N_SRC, 4: number of requesters, 2..8.
- HEADER_EN, 1: 1 = emit a header byte before each packet; 0 = no header.
- HEADER_BASE, 8'hA0: header byte is HEADER_BASE | granted index. The low 3 bits of HEADER_BASE must be 0.
- TIMEOUT_CYC, 256: number of consecutive DATA-state cycles with the granted source's tvalid low before the grant is revoked. 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- s_axis_tdata_i  in  8*N_SRC  source bytes; source i occupies bits [8i+7:8i].
- s_axis_tvalid_i  in  N_SRC  per-source valid.
- s_axis_tlast_i  in  N_SRC  per-source end-of-packet.
- s_axis_tready_o  out  N_SRC  per-source ready; combinational.
- m_axis_tdata_o  out  8  byte to the UART; registered.
- m_axis_tvalid_o  out  1  registered valid.
- m_axis_tready_i  in  1  UART ready.
- grant_o  out  N_SRC  one-hot current owner; all zero when idle.
- busy_o  out  1  high whenever the state is not IDLE.
- abort_o  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- **Output register.** Holds one byte. It is "free" when !m_axis_tvalid_o || m_axis_tready_i. It loads when free and a byte (header or data) is offered. Otherwise m_axis_tvalid_o clears on handshake. m_axis_tdata_o is held stable while valid is high and ready is low.
- **Round-robin pointer `ptr`.** Holds the last-served index and resets to N_SRC-1, so source 0 wins first. The search order is ptr+1, ptr+2, … modulo N_SRC. Winners are chosen by tvalid only.
- **IDLE.**
  - If any tvalid is high, grant the first requester in search order.
  - Go to HEADER if HEADER_EN, else DATA.
  - Otherwise stay in IDLE.
- **HEADER.** When the output register is free, load HEADER_BASE | index and go to DATA.
- **DATA.**
  - s_axis_tready_o[g] = (register free). All other readies are 0.
  - Each accepted beat is loaded into the output register.
  - When a beat with tlast is accepted: go to IDLE, set ptr = g, clear grant_o.
- **Timeout.**
  - In DATA, a counter increments on each cycle where s_axis_tvalid_i[g] is low and clears on each cycle where it is high.
  - When the counter reaches TIMEOUT_CYC (nonzero): go to IDLE, set ptr = g, pulse abort_o.
  - No byte is appended on abort. The UART simply stops receiving that packet.
- **Ownership.** Only the granted source is ever ready. tvalid changes on other sources have no effect until the next IDLE.
- **Zero-length packets.** A first beat with tlast is legal: the packet is the header plus one byte.
- **Reset.** Returns state to IDLE and sets ptr = N_SRC-1. All of grant_o, busy_o, abort_o, m_axis_tvalid_o, s_axis_tready_o and the timeout counter go to 0. Any byte held in the output register is discarded. Reset mid-packet truncates that packet.

## Timing
- With HEADER_EN=1 and m_axis_tready_i=1, tvalid rising in IDLE at cycle 0 gives:
  - grant_o at cycle 1;
  - the header on m_axis at cycle 2;
  - the first data byte accepted at cycle 2 and visible on m_axis at cycle 3.
- With HEADER_EN=0: first data byte accepted at cycle 1, visible at cycle 2.
- Throughput in DATA is one byte per cycle while the UART is ready.
- The last beat is accepted at cycle t, busy_o falls at t+1, and the next grant is decided in IDLE at t+1 (visible at t+2). This gives one idle cycle between packets.
- Backpressure: with m_axis_tready_i low, the register stays full, tready_o is low, and no state advances except the timeout counter.
- abort_o is registered: it is high for exactly the cycle in which state returns to IDLE.

## Test plan
- **Single packet.** Source 2 sends 0x11, 0x22, 0x33(last), UART always ready. Required: m_axis carries 0xA2, 0x11, 0x22, 0x33 on consecutive cycles starting at cycle 2; grant_o = 4'b0100 for 4 cycles; then idle.
- **Round-robin fairness.** Sources 0 and 1 each stream 2-byte packets continuously. Required: packets alternate 0, 1, 0, 1 with headers 0xA0/0xA1, and no packet is interleaved.
- **Backpressure.** Toggle m_axis_tready_i every cycle during a 5-byte packet. Required: all 6 bytes arrive in order, no byte is duplicated or lost, and tdata is stable across every stall.
- **Timeout.** TIMEOUT_CYC=8. Source 1 sends one byte without last, then drops tvalid. Required: abort_o pulses 8 cycles after tvalid drops, busy_o falls, and source 3 (pending) is granted next.
- **Reset mid-packet.** Assert rst_i for 1 cycle during byte 2. Required: every output is 0 on the next cycle, and the following grant goes to source 0 if several are valid.
- **HEADER_EN=0.** Same stimulus as the single-packet test. Required: m_axis carries 0x11, 0x22, 0x33 only, with the first byte at cycle 2.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-wide AXI-stream bundle between N_SRC packet sources and the UART transmit port.
// The arbiter takes the slave view; sources and UART sit on the master view.
interface uart_tx_arbiter_if #(
    parameter int N_SRC = 4
);
    logic [8*N_SRC-1:0] s_axis_tdata;
    logic [N_SRC-1:0]   s_axis_tvalid;
    logic [N_SRC-1:0]   s_axis_tlast;
    logic [N_SRC-1:0]   s_axis_tready;
    logic [7:0]         m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the UART byte stream, with optional
// source-ID header per packet and a stall timeout that revokes a dead grant.
module uart_tx_arbiter #(
    parameter int         N_SRC       = 4,
    parameter bit         HEADER_EN   = 1'b1,
    parameter logic [7:0] HEADER_BASE = 8'hA0,
    parameter int         TIMEOUT_CYC = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart_tx_arbiter_if.slave   axis,
    output logic [N_SRC-1:0]   grant_o,
    output logic               busy_o,
    output logic               abort_o
);
    localparam int IW = $clog2(N_SRC);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] win;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          abort_q, abort_d;
    logic [7:0]    mdata_q, mdata_d;
    logic          mvalid_q, mvalid_d;
    logic          free;
    logic          src_vld;
    logic          src_last;
    logic [7:0]    src_data;

    assign free     = !mvalid_q || axis.m_axis_tready;
    assign src_vld  = axis.s_axis_tvalid[gnt_q];
    assign src_last = axis.s_axis_tlast[gnt_q];
    assign src_data = axis.s_axis_tdata[{gnt_q, 3'b000} +: 8];

    // Walk the search order backwards so the nearest requester after ptr wins.
    always_comb begin : p_win
        int idx;
        win = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % N_SRC;
            if (axis.s_axis_tvalid[idx]) win = IW'(idx);
        end
    end

    always_comb begin
        state_d            = state_q;
        ptr_d              = ptr_q;
        gnt_d              = gnt_q;
        cnt_d              = cnt_q;
        abort_d            = 1'b0;
        mvalid_d           = mvalid_q;
        mdata_d            = mdata_q;
        axis.s_axis_tready = '0;
        if (mvalid_q && axis.m_axis_tready) mvalid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (|axis.s_axis_tvalid) begin
                    gnt_d   = win;
                    state_d = HEADER_EN ? S_HEADER : S_DATA;
                end
            end
            S_HEADER: begin
                if (free) begin
                    mvalid_d = 1'b1;
                    mdata_d  = HEADER_BASE | 8'(gnt_q);
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                axis.s_axis_tready[gnt_q] = free;
                if (src_vld) begin
                    cnt_d = '0;
                    if (free) begin
                        mvalid_d = 1'b1;
                        mdata_d  = src_data;
                        if (src_last) begin
                            state_d = S_IDLE;
                            ptr_d   = gnt_q;
                        end
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    // Counts even under UART backpressure: only source silence matters.
                    if (32'(cnt_q) + 1 == TIMEOUT_CYC) begin
                        state_d = S_IDLE;
                        ptr_d   = gnt_q;
                        abort_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= IW'(N_SRC - 1);
            gnt_q    <= '0;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
        end
    end

    assign busy_o             = (state_q != S_IDLE);
    assign grant_o            = busy_o ? ({{(N_SRC-1){1'b0}}, 1'b1} << gnt_q) : '0;
    assign abort_o            = abort_q;
    assign axis.m_axis_tvalid = mvalid_q;
    assign axis.m_axis_tdata  = mdata_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter; expected byte stream comes from
// a packet-level round-robin model over per-source packet queues.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] tdata;
    logic [N-1:0]   tvalid, tlast;
    logic           m_tready;
    logic [N-1:0]   gnt_a, gnt_b;
    logic           busy_a, busy_b, abort_a, abort_b;

    uart_tx_arbiter_if #(.N_SRC(N)) ifa ();
    uart_tx_arbiter_if #(.N_SRC(N)) ifb ();

    assign ifa.s_axis_tdata  = tdata;
    assign ifa.s_axis_tvalid = tvalid;
    assign ifa.s_axis_tlast  = tlast;
    assign ifa.m_axis_tready = m_tready;
    assign ifb.s_axis_tdata  = tdata;
    assign ifb.s_axis_tvalid = tvalid;
    assign ifb.s_axis_tlast  = tlast;
    assign ifb.m_axis_tready = m_tready;

    uart_tx_arbiter #(.N_SRC(N), .HEADER_EN(1'b1), .HEADER_BASE(8'hA0), .TIMEOUT_CYC(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .axis(ifa), .grant_o(gnt_a), .busy_o(busy_a), .abort_o(abort_a));
    uart_tx_arbiter #(.N_SRC(N), .HEADER_EN(1'b0), .HEADER_BASE(8'hA0), .TIMEOUT_CYC(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .axis(ifb), .grant_o(gnt_b), .busy_o(busy_b), .abort_o(abort_b));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Source model state
    logic [7:0] sd_q [N][$];
    bit         sl_q [N][$];
    bit         in_pkt [N];
    int         gap_cnt [N];
    bit         gaps_en;
    bit         sel_b;
    logic [N-1:0] hs;
    logic [7:0] exp_q [$];
    bit         mon_en = 1'b0;

    task automatic add_byte(input int s, input logic [7:0] b, input bit last);
        sd_q[s].push_back(b);
        sl_q[s].push_back(last);
    endtask

    task automatic add_rand_pkt(input int s, input int len);
        for (int j = 0; j < len; j++) add_byte(s, 8'($urandom_range(0, 255)), j == len - 1);
    endtask

    function automatic bit srcs_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (sd_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Every source with queued packets keeps tvalid high between its packets, so
    // the packet order is plain round-robin over the non-empty sources.
    task automatic build_exp(input bit hdr);
        logic [7:0] cd [N][$];
        bit         cl [N][$];
        int ptr = N - 1;
        int idx = 0;
        bit any;
        bit l;
        for (int i = 0; i < N; i++) begin cd[i] = sd_q[i]; cl[i] = sl_q[i]; end
        exp_q.delete();
        do begin
            any = 1'b0;
            for (int k = 1; k <= N && !any; k++) begin
                idx = (ptr + k) % N;
                if (cd[idx].size() != 0) any = 1'b1;
            end
            if (any) begin
                if (hdr) exp_q.push_back(8'hA0 | 8'(idx));
                do begin
                    exp_q.push_back(cd[idx].pop_front());
                    l = cl[idx].pop_front();
                end while (!l);
                ptr = idx;
            end
        end while (any);
    endtask

    task automatic drive_src();
        bit was_v;
        for (int i = 0; i < N; i++) begin
            was_v = tvalid[i];
            if (hs[i]) begin
                void'(sd_q[i].pop_front());
                in_pkt[i] = !sl_q[i].pop_front();
            end
            tvalid[i] = 1'b0;
            tlast[i]  = 1'b0;
            tdata[8*i +: 8] = 8'h00;
            if (sd_q[i].size() != 0) begin
                if (gaps_en && in_pkt[i] && (hs[i] || !was_v) && gap_cnt[i] < 3 &&
                    $urandom_range(0, 3) == 0) begin
                    gap_cnt[i]++;
                end else begin
                    gap_cnt[i] = 0;
                    tvalid[i]  = 1'b1;
                    tlast[i]   = sl_q[i][0];
                    tdata[8*i +: 8] = sd_q[i][0];
                end
            end
        end
    endtask

    task automatic sample_hs();
        hs = tvalid & (sel_b ? ifb.s_axis_tready : ifa.s_axis_tready);
    endtask

    task automatic do_reset();
        rst = 1'b1; tvalid = '0; tlast = '0; tdata = '0; m_tready = 1'b1; hs = '0;
        gaps_en = 1'b0; sel_b = 1'b0;
        for (int i = 0; i < N; i++) begin
            sd_q[i].delete(); sl_q[i].delete(); in_pkt[i] = 1'b0; gap_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Stream, stall-stability and ownership monitor on DUT A
    bit         pv_stall = 1'b0;
    logic [7:0] pv_data = '0;
    always @(negedge clk) begin
        if (!rst && pv_stall) begin
            chk("stall_valid", 32'(ifa.m_axis_tvalid), 32'd1);
            chk("stall_data", 32'(ifa.m_axis_tdata), 32'(pv_data));
        end
        if (!rst && |ifa.s_axis_tready)
            chk("ready_owner", 32'(ifa.s_axis_tready & ~gnt_a), 32'd0);
        if (mon_en && ifa.m_axis_tvalid && ifa.m_axis_tready) begin
            chk("stream_byte", 32'(ifa.m_axis_tdata),
                (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'hDEAD);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        pv_stall = !rst && ifa.m_axis_tvalid && !ifa.m_axis_tready;
        pv_data  = ifa.m_axis_tdata;
    end

    // mode: 0 UART always ready, 1 toggling, 2 random
    task automatic run_traffic(input int mode, input string tag);
        bit done = 1'b0;
        build_exp(1'b1);
        sel_b  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1 drive_src();
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            sample_hs();
            done = (exp_q.size() == 0) && !busy_a && srcs_empty();
            @(posedge clk); #1 drive_src();
            m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? !m_tready : ($urandom_range(0, 3) != 0);
        end
        mon_en = 1'b0;
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic single_pkt(input bit use_b, input string tag);
        logic [7:0] stream [4];
        int hdr;
        logic [N-1:0] g;
        logic mv;
        logic [7:0] md;
        do_reset();
        sel_b = use_b;
        hdr = use_b ? 0 : 1;
        if (use_b) stream = '{8'h11, 8'h22, 8'h33, 8'h00};
        else       stream = '{8'hA2, 8'h11, 8'h22, 8'h33};
        add_byte(2, 8'h11, 1'b0); add_byte(2, 8'h22, 1'b0); add_byte(2, 8'h33, 1'b1);
        @(posedge clk); #1 drive_src();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            g  = use_b ? gnt_b : gnt_a;
            mv = use_b ? ifb.m_axis_tvalid : ifa.m_axis_tvalid;
            md = use_b ? ifb.m_axis_tdata : ifa.m_axis_tdata;
            chk($sformatf("%s_grant_c%0d", tag, c), 32'(g),
                (c >= 1 && c <= 3 + hdr) ? 32'h4 : 32'h0);
            chk($sformatf("%s_mvalid_c%0d", tag, c), 32'(mv), 32'(c >= 2 && c <= 4 + hdr));
            if (c >= 2 && c <= 4 + hdr)
                chk($sformatf("%s_mdata_c%0d", tag, c), 32'(md), 32'(stream[c-2]));
            sample_hs();
            @(posedge clk); #1 drive_src();
        end
    endtask

    task automatic timeout_test();
        do_reset();
        @(posedge clk); #1;
        tdata[15:8] = 8'h55; tlast[1] = 1'b0; tvalid[1] = 1'b1;
        tdata[31:24] = 8'h77; tlast[3] = 1'b1; tvalid[3] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 2)  chk("to_accept", 32'(ifa.s_axis_tready[1]), 32'd1);
            if (c == 3)  chk("to_byte", 32'(ifa.m_axis_tdata), 32'h55);
            if (c == 5)  chk("to_other_ready", 32'(ifa.s_axis_tready[3]), 32'd0);
            if (c == 10) chk("to_busy_before", 32'(busy_a), 32'd1);
            if (c == 11) chk("to_busy_after", 32'(busy_a), 32'd0);
            if (c == 12) chk("to_next_grant", 32'(gnt_a), 32'h8);
            if (c == 13) chk("to_next_hdr", 32'(ifa.m_axis_tdata), 32'hA3);
            chk($sformatf("to_abort_c%0d", c), 32'(abort_a), 32'(c == 11));
            @(posedge clk); #1;
            if (c == 2) tvalid[1] = 1'b0;
        end
    endtask

    task automatic reset_mid_test();
        do_reset();
        add_byte(2, 8'h11, 1'b0); add_byte(2, 8'h22, 1'b0); add_byte(2, 8'h33, 1'b1);
        @(posedge clk); #1 drive_src();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); sample_hs();
            @(posedge clk); #1 drive_src();
        end
        rst = 1'b1;
        tvalid = 4'b1111; tlast = 4'b1111; tdata = 32'h44332211;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rm_grant", 32'(gnt_a), 32'd0);
        chk("rm_busy", 32'(busy_a), 32'd0);
        chk("rm_abort", 32'(abort_a), 32'd0);
        chk("rm_mvalid", 32'(ifa.m_axis_tvalid), 32'd0);
        chk("rm_mdata", 32'(ifa.m_axis_tdata), 32'd0);
        chk("rm_tready", 32'(ifa.s_axis_tready), 32'd0);
        chk("rm_b_busy", 32'(busy_b), 32'd0);
        @(negedge clk);
        chk("rm_first_grant", 32'(gnt_a), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_grant_a", 32'(gnt_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_abort_a", 32'(abort_a), 32'd0);
        chk("rst_mvalid_a", 32'(ifa.m_axis_tvalid), 32'd0);
        chk("rst_tready_a", 32'(ifa.s_axis_tready), 32'd0);
        chk("rst_grant_b", 32'(gnt_b), 32'd0);
        chk("rst_mvalid_b", 32'(ifb.m_axis_tvalid), 32'd0);

        single_pkt(1'b0, "single");
        single_pkt(1'b1, "nohdr");

        do_reset();
        for (int p = 0; p < 3; p++) begin
            add_rand_pkt(0, 2);
            add_rand_pkt(1, 2);
        end
        run_traffic(0, "fair");

        do_reset();
        add_rand_pkt(0, 5);
        run_traffic(1, "bp");

        timeout_test();
        reset_mid_test();

        for (int r = 0; r < 4; r++) begin
            do_reset();
            gaps_en = 1'b1;
            for (int i = 0; i < N; i++)
                for (int p = $urandom_range(0, 3); p > 0; p--)
                    add_rand_pkt(i, $urandom_range(1, 5));
            run_traffic(2, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
